systolic_matmul_drain: RTL and testbench
========================================

// Module: systolic_matmul_drain
// PURPOSE
//  Output stage downstream of the systolic integer MX matmul array. On a start pulse, waits
//  a fixed LATENCY cycles, then captures the parallel C/S_C result matrices into a shadow
//  register. It streams them out one row per beat over a valid/ready interface, so the
//  array can take new operands while the previous result drains.
// PARAMETERS
//  x_rows       4  rows of C (= number of output beats per result)
//  y_cols       4  columns of C (= elements per beat)
//  out_width    8  signed width of each C element
//  scale_width  8  unsigned width of each S_C element
//  LATENCY      1  cycles from i_start edge to valid C_i/S_C_i at the array output; 0 legal
// PORTS
//  i_clk            in   1                      clock, all logic rising-edge
//  i_rst            in   1                      async reset, active-high
//  i_start          in   1                      operands presented to array this cycle
//  C_i              in   [x_rows][y_cols]x out_width (signed)  array result
//  S_C_i            in   [x_rows][y_cols]x scale_width         array result scales
//  o_busy           out  1                      high in WAIT or DRAIN
//  o_start_dropped  out  1                      1-cycle pulse: i_start ignored (busy)
//  o_valid          out  1                      beat valid
//  i_ready          in   1                      downstream accepts beat
//  o_data           out  [y_cols]x out_width    row o_row_idx of captured C
//  o_scale          out  [y_cols]x scale_width  row o_row_idx of captured S_C
//  o_row_idx        out  $clog2(x_rows) (min 1) current row index
//  o_last           out  1                      high with final row (x_rows-1)
// BEHAVIOUR
//  - One clock i_clk; reset is asynchronous and active-high on i_rst.
//  - Reset: state IDLE, counters 0, shadow regs 0. All outputs 0: o_valid, o_busy,
//    o_last, o_start_dropped, o_data, o_scale and o_row_idx.
//  - States IDLE, WAIT, DRAIN (registered):
//    IDLE : i_start & LATENCY>0 -> WAIT, lat_cnt<=LATENCY-1.
//           i_start & LATENCY==0 -> capture C_i/S_C_i on this edge, then go to DRAIN.
//    WAIT : lat_cnt==0 -> capture C_i/S_C_i, row<=0, then go to DRAIN.
//           Otherwise lat_cnt<=lat_cnt-1.
//    DRAIN: o_valid=1; a beat transfers on o_valid&i_ready and then row<=row+1.
//           A transfer with row==x_rows-1 goes to IDLE, unless a start is accepted
//           on that same cycle.
//  - Capture edge: i_start is sampled at edge t and the capture happens at edge
//    t+LATENCY. The first o_valid is in the cycle after capture.
//  - o_data/o_scale/o_row_idx/o_last are driven combinationally from the shadow reg and
//    the row counter. They are stable while o_valid & !i_ready; the shadow reg is never
//    rewritten during DRAIN.
//  - o_last = (state==DRAIN) & (row==x_rows-1).
//  - Back-to-back: i_start on the cycle of the final handshake is accepted. The next state
//    is WAIT (LATENCY>0), or DRAIN with fresh capture and row 0 (LATENCY==0). No bubble
//    beyond LATENCY.
//  - i_start in WAIT, or in DRAIN other than the final-handshake cycle: ignored, and
//    o_start_dropped=1 next cycle. State and data are unaffected.
//  - Width rule: no arithmetic on data; values pass bit-exact, with signedness preserved.
//  - Reset mid-WAIT/DRAIN: immediate return to IDLE with outputs 0. A partial drain is
//    discarded and is not resumed.
//  - x_rows==1: the single beat carries o_last=1.
// STRUCTURE
//  - systolic_pkg holds:
//    - typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} drain_state_t;
//    - function clog2_min1() for index/counter widths.
//  - Single module, no sub-module. FSM, lat_cnt, row counter and shadow reg are inline.
//  - Shadow reg size: x_rows*y_cols*(out_width+scale_width) flops.
// TESTING
//  1 Reset then idle, C_i toggling, i_ready=1 -> o_valid/o_busy stay 0 and all outputs stay 0.
//  2 LATENCY=1, start@t0, C_i[r][c]=r*4+c valid at t1, i_ready=1 -> 4 beats t2..t5,
//    rows 0..3. Row 2 data={8,9,10,11}. o_last only at t5; o_busy falls after t5.
//  3 Backpressure: i_ready=0 for 3 cycles at row 1 -> row 1 data held, then beats resume.
//    Total 4 beats, none lost or duplicated.
//  4 Negative/scale passthrough: C_i=-128 (8'h80) everywhere, S_C_i=8'hFF -> o_data
//    elements are 8'h80 and o_scale elements are 8'hFF.
//  5 i_start during WAIT and mid-DRAIN -> o_start_dropped pulses once each and the drain
//    is unchanged. i_start on the final-handshake cycle -> a second result drains after
//    LATENCY with no drop.
//  6 i_rst asserted asynchronously mid-DRAIN (row 2) -> o_valid=0 immediately. A new start
//    then drains from row 0 with new data.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matmul output drain stage.
package systolic_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} drain_state_t;

    // Width for an index/counter covering 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_matmul_drain.sv
// Captures the array result LATENCY cycles after i_start and streams it out one row per beat.
// Latency: first o_valid one cycle after capture. Backpressure: beat and row held while i_ready is low.
module systolic_matmul_drain
    import systolic_pkg::*;
#(
    parameter int x_rows      = 4,
    parameter int y_cols      = 4,
    parameter int out_width   = 8,
    parameter int scale_width = 8,
    parameter int LATENCY     = 1
) (
    input  logic                                                  i_clk,
    input  logic                                                  i_rst,
    input  logic                                                  i_start,
    input  logic signed [x_rows-1:0][y_cols-1:0][out_width-1:0]   C_i,
    input  logic        [x_rows-1:0][y_cols-1:0][scale_width-1:0] S_C_i,
    output logic                                                  o_busy,
    output logic                                                  o_start_dropped,
    output logic                                                  o_valid,
    input  logic                                                  i_ready,
    output logic signed [y_cols-1:0][out_width-1:0]               o_data,
    output logic        [y_cols-1:0][scale_width-1:0]             o_scale,
    output logic        [clog2_min1(x_rows)-1:0]                  o_row_idx,
    output logic                                                  o_last
);

    localparam int RW = clog2_min1(x_rows);
    localparam int LW = clog2_min1(LATENCY + 1);
    localparam logic [LW-1:0] LAT_INIT = LW'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [RW-1:0] LAST_ROW = RW'(x_rows - 1);

    drain_state_t state_q, state_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic          drop_q, drop_d;
    logic [x_rows-1:0][y_cols-1:0][out_width-1:0]   c_q, c_d;
    logic [x_rows-1:0][y_cols-1:0][scale_width-1:0] s_q, s_d;

    logic beat_xfer;
    logic final_xfer;
    logic accept_start;
    logic capture;

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        row_d        = row_q;
        drop_d       = 1'b0;
        c_d          = c_q;
        s_d          = s_q;
        capture      = 1'b0;
        beat_xfer    = (state_q == ST_DRAIN) && i_ready;
        final_xfer   = beat_xfer && (row_q == LAST_ROW);
        // A start is only taken when the shadow reg is free or freeing this very cycle.
        accept_start = i_start && ((state_q == ST_IDLE) || final_xfer);

        case (state_q)
            ST_IDLE: begin
            end
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    capture = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (beat_xfer) begin
                    if (final_xfer) begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept_start) begin
            if (LATENCY > 0) begin
                state_d   = ST_WAIT;
                lat_cnt_d = LAT_INIT;
            end else begin
                capture = 1'b1;
            end
        end

        if (i_start && !accept_start) begin
            drop_d = 1'b1;
        end

        if (capture) begin
            c_d     = C_i;
            s_d     = S_C_i;
            row_d   = '0;
            state_d = ST_DRAIN;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
            row_q     <= '0;
            drop_q    <= 1'b0;
            c_q       <= '0;
            s_q       <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            row_q     <= row_d;
            drop_q    <= drop_d;
            c_q       <= c_d;
            s_q       <= s_d;
        end
    end

    assign o_valid         = (state_q == ST_DRAIN);
    assign o_busy          = (state_q != ST_IDLE);
    assign o_last          = (state_q == ST_DRAIN) && (row_q == LAST_ROW);
    assign o_start_dropped = drop_q;
    assign o_row_idx       = row_q;
    assign o_data          = c_q[row_q];
    assign o_scale         = s_q[row_q];

endmodule

// File: tb/tb_systolic_matmul_drain.sv
// Directed bench for systolic_matmul_drain at default parameters (4x4, 8-bit, LATENCY=1).
module tb_systolic_matmul_drain;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic                   i_start;
    logic                   i_ready;
    logic [3:0][3:0][7:0]   c_in;
    logic [3:0][3:0][7:0]   s_in;
    logic                   o_busy;
    logic                   o_start_dropped;
    logic                   o_valid;
    logic [3:0][7:0]        o_data;
    logic [3:0][7:0]        o_scale;
    logic [1:0]             o_row_idx;
    logic                   o_last;

    int n_checks = 0;
    int n_err    = 0;
    int beats    = 0;
    int b0;
    logic [31:0] row_seen [4];

    systolic_matmul_drain dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .C_i            (c_in),
        .S_C_i          (s_in),
        .o_busy         (o_busy),
        .o_start_dropped(o_start_dropped),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_scale        (o_scale),
        .o_row_idx      (o_row_idx),
        .o_last         (o_last)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (!i_rst && o_valid && i_ready) beats <= beats + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge i_clk);
    endtask

    function automatic logic [31:0] row_of(input logic [7:0] base, input int r);
        logic [31:0] v;
        for (int c = 0; c < 4; c++) v[c*8 +: 8] = base + 8'(r*4 + c);
        return v;
    endfunction

    task automatic set_pat(input logic [7:0] bc, input logic [7:0] bs);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                c_in[r][c] = bc + 8'(r*4 + c);
                s_in[r][c] = bs + 8'(r*4 + c);
            end
    endtask

    // Expects to be at a negedge with row 0 presented and i_ready high.
    task automatic drain4(input string tag, input logic [7:0] bc, input logic [7:0] bs);
        for (int r = 0; r < 4; r++) begin
            row_seen[r] = o_data;
            chk($sformatf("%s_valid_r%0d", tag, r), 64'(o_valid), 64'd1);
            chk($sformatf("%s_row_r%0d", tag, r), 64'(o_row_idx), 64'(r));
            chk($sformatf("%s_data_r%0d", tag, r), 64'(o_data), 64'(row_of(bc, r)));
            chk($sformatf("%s_scale_r%0d", tag, r), 64'(o_scale), 64'(row_of(bs, r)));
            chk($sformatf("%s_last_r%0d", tag, r), 64'(o_last), 64'(r == 3));
            nxt();
        end
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b1; c_in = '0; s_in = '0;
        repeat (2) nxt();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        chk("rst_drop", 64'(o_start_dropped), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_scale", 64'(o_scale), 64'd0);
        chk("rst_row", 64'(o_row_idx), 64'd0);
        i_rst = 1'b0;

        // 1: idle with toggling inputs
        for (int k = 0; k < 4; k++) begin
            c_in = ~c_in; s_in = ~s_in;
            nxt();
            chk("idle_valid", 64'(o_valid), 64'd0);
            chk("idle_busy", 64'(o_busy), 64'd0);
            chk("idle_data", 64'(o_data), 64'd0);
            chk("idle_scale", 64'(o_scale), 64'd0);
            chk("idle_last", 64'(o_last), 64'd0);
        end

        // 2: basic drain; data at start edge is garbage, real data valid one cycle later
        i_start = 1'b1; set_pat(8'hA0, 8'hC0);
        b0 = beats;
        nxt();
        i_start = 1'b0; set_pat(8'h00, 8'h40);
        chk("t2_wait_busy", 64'(o_busy), 64'd1);
        chk("t2_wait_valid", 64'(o_valid), 64'd0);
        nxt();
        set_pat(8'hEE, 8'hEE);
        drain4("t2", 8'h00, 8'h40);
        chk("t2_row2_literal", 64'(row_seen[2]), 64'h0B0A0908);
        chk("t2_end_valid", 64'(o_valid), 64'd0);
        chk("t2_end_busy", 64'(o_busy), 64'd0);
        chk("t2_beats", 64'(beats - b0), 64'd4);

        // 3: backpressure at row 1
        i_start = 1'b1; set_pat(8'h20, 8'h60);
        b0 = beats;
        nxt();
        i_start = 1'b0;
        nxt();
        chk("t3_r0_data", 64'(o_data), 64'(row_of(8'h20, 0)));
        nxt();
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nxt();
            chk("t3_hold_valid", 64'(o_valid), 64'd1);
            chk("t3_hold_row", 64'(o_row_idx), 64'd1);
            chk("t3_hold_data", 64'(o_data), 64'(row_of(8'h20, 1)));
        end
        i_ready = 1'b1;
        for (int r = 1; r < 4; r++) begin
            chk("t3_resume_row", 64'(o_row_idx), 64'(r));
            chk("t3_resume_data", 64'(o_data), 64'(row_of(8'h20, r)));
            nxt();
        end
        chk("t3_beats", 64'(beats - b0), 64'd4);
        chk("t3_end_valid", 64'(o_valid), 64'd0);

        // 4: negative and full-scale passthrough
        c_in = {16{8'h80}}; s_in = {16{8'hFF}};
        i_start = 1'b1;
        nxt();
        i_start = 1'b0;
        nxt();
        for (int r = 0; r < 4; r++) begin
            chk("t4_data", 64'(o_data), 64'h80808080);
            chk("t4_scale", 64'(o_scale), 64'hFFFFFFFF);
            nxt();
        end

        // 5: dropped starts in WAIT and mid-DRAIN, accepted start on final handshake
        set_pat(8'h30, 8'h10);
        i_start = 1'b1;
        nxt();
        chk("t5_wait_busy", 64'(o_busy), 64'd1);
        chk("t5_wait_drop", 64'(o_start_dropped), 64'd0);
        nxt();
        i_start = 1'b0;
        chk("t5_drop1", 64'(o_start_dropped), 64'd1);
        chk("t5_r0_data", 64'(o_data), 64'(row_of(8'h30, 0)));
        nxt();
        chk("t5_drop1_clr", 64'(o_start_dropped), 64'd0);
        chk("t5_r1_row", 64'(o_row_idx), 64'd1);
        i_start = 1'b1;
        nxt();
        i_start = 1'b0;
        chk("t5_drop2", 64'(o_start_dropped), 64'd1);
        chk("t5_r2_row", 64'(o_row_idx), 64'd2);
        chk("t5_r2_data", 64'(o_data), 64'(row_of(8'h30, 2)));
        nxt();
        chk("t5_r3_last", 64'(o_last), 64'd1);
        chk("t5_r3_drop", 64'(o_start_dropped), 64'd0);
        i_start = 1'b1;
        nxt();
        i_start = 1'b0; set_pat(8'h50, 8'h90);
        chk("t5_b2b_busy", 64'(o_busy), 64'd1);
        chk("t5_b2b_valid", 64'(o_valid), 64'd0);
        chk("t5_b2b_drop", 64'(o_start_dropped), 64'd0);
        nxt();
        drain4("t5b", 8'h50, 8'h90);
        chk("t5_end_busy", 64'(o_busy), 64'd0);

        // 6: async reset mid-DRAIN, then a fresh result from row 0
        set_pat(8'h70, 8'h05);
        i_start = 1'b1;
        nxt();
        i_start = 1'b0;
        nxt();
        nxt();
        nxt();
        chk("t6_pre_row", 64'(o_row_idx), 64'd2);
        #2 i_rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(o_valid), 64'd0);
        chk("t6_rst_busy", 64'(o_busy), 64'd0);
        chk("t6_rst_data", 64'(o_data), 64'd0);
        chk("t6_rst_row", 64'(o_row_idx), 64'd0);
        chk("t6_rst_last", 64'(o_last), 64'd0);
        nxt();
        i_rst = 1'b0;
        set_pat(8'hB0, 8'h3C);
        i_start = 1'b1;
        nxt();
        i_start = 1'b0;
        nxt();
        drain4("t6", 8'hB0, 8'h3C);
        chk("t6_end_valid", 64'(o_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
